// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV immediate generator with a 2-entry head/skid output buffer
// Optional PC adder (in_pc/out_target) enabled by defining IMM_GEN_PCADD_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
`ifdef IMM_GEN_PCADD_EN
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] out_target,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_R = 3'd6;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011, OP_JALR = 7'b1100111,
                         OP_SYSTEM = 7'b1110011, OP_IMM32 = 7'b0011011, OP_STORE = 7'b0100011,
                         OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_OP = 7'b0110011, OP_OP32 = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
`ifdef IMM_GEN_PCADD_EN
    logic [XLEN-1:0] tgt;
`endif
  } entry_t;

  entry_t dec, head_q, head_d, skid_q, skid_d;
  logic   head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic   accept, pop, is_shift;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh5, imm_sh6;

  assign imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign imm_u   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j   = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
  assign imm_sh5 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign imm_sh6 = {{(XLEN-6){1'b0}}, in_instr[25:20]};
  // funct3 001/101 are the shift-immediate encodings
  assign is_shift = (in_instr[13:12] == 2'b01);

  always_comb begin
    dec = '0;
    case (in_instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM: begin dec.fmt = FMT_I; dec.imm = imm_i; end
      OP_IMM: begin
        dec.fmt = FMT_I;
        dec.imm = is_shift ? ((XLEN == 64) ? imm_sh6 : imm_sh5) : imm_i;
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          dec.imm = is_shift ? imm_sh5 : imm_i;
        end else begin
          dec.ill = 1'b1;
        end
      end
      OP_STORE:        begin dec.fmt = FMT_S; dec.imm = imm_s; end
      OP_BRANCH:       begin dec.fmt = FMT_B; dec.imm = imm_b; end
      OP_LUI, OP_AUIPC: begin dec.fmt = FMT_U; dec.imm = imm_u; end
      OP_JAL:          begin dec.fmt = FMT_J; dec.imm = imm_j; end
      OP_OP:           dec.fmt = FMT_R;
      OP_OP32: begin
        if (XLEN == 64) dec.fmt = FMT_R;
        else            dec.ill = 1'b1;
      end
      default:         dec.ill = 1'b1;
    endcase
`ifdef IMM_GEN_PCADD_EN
    if (dec.fmt != FMT_NONE && dec.fmt != FMT_R) dec.tgt = in_pc + dec.imm;
`endif
  end

  assign accept = in_valid && in_ready;
  assign pop    = head_v_q && out_ready;

  // skid can only be full while in_ready is low, so pop+accept never meets a full skid
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        head_d = dec;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (accept) begin
      if (head_v_q) begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end else begin
        head_d   = dec;
        head_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      skid_q   <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready    = !skid_v_q;
  assign out_valid   = head_v_q;
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.ill;
`ifdef IMM_GEN_PCADD_EN
  assign out_target  = head_q.tgt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe, XLEN=32 and XLEN=64 instances side by side
// Honours IMM_GEN_PCADD_EN when defined.
module tb_imm_gen_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;
  logic        in_ready32, out_valid32, out_ill32, in_ready64, out_valid64, out_ill64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt32, out_fmt64;
`ifdef IMM_GEN_PCADD_EN
  logic [63:0] pc = '0;
  logic [31:0] out_tgt32;
  logic [63:0] out_tgt64;
`endif

  int checks = 0, failures = 0, pops = 0;
  bit rand_rdy = 1'b0, ready_force = 1'b0, grp_done = 1'b0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } exp_t;

  exp_t q32[$], q64[$];

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
`ifdef IMM_GEN_PCADD_EN
    .in_pc(pc[31:0]), .out_target(out_tgt32),
`endif
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_ill32));

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
`ifdef IMM_GEN_PCADD_EN
    .in_pc(pc), .out_target(out_tgt64),
`endif
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_ill64));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] tgt_of(input logic [2:0] fmt, input logic [63:0] pcv,
                                         input logic [63:0] imm, input int xl);
    logic [63:0] t;
    t = (fmt == 3'd0 || fmt == 3'd6) ? 64'd0 : pcv + imm;
    if (xl == 32) t[63:32] = '0;
    return t;
  endfunction

  // Reference: fields pulled out of a sign-extended word with arithmetic shifts and masks
  function automatic exp_t model(input logic [31:0] ins, input int xl, input logic [63:0] pcv);
    exp_t   e;
    longint sx, i_s, s_hi, top;
    bit     sh;
    e    = '0;
    sx   = longint'($signed(ins));
    i_s  = sx >>> 20;
    s_hi = sx >>> 25;
    top  = sx >>> 31;
    sh   = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    case (ins[6:0])
      7'h03, 7'h67, 7'h73: begin e.fmt = 1; e.imm = i_s; end
      7'h13: begin
        e.fmt = 1;
        e.imm = !sh ? i_s : (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
      end
      7'h1B: begin
        if (xl == 64) begin e.fmt = 1; e.imm = sh ? 64'(ins[24:20]) : i_s; end
        else e.ill = 1;
      end
      7'h23: begin e.fmt = 2; e.imm = (s_hi << 5) | 64'(ins[11:7]); end
      7'h63: begin
        e.fmt = 3;
        e.imm = (top << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 4; e.imm = sx & ~64'hFFF; end
      7'h6F: begin
        e.fmt = 5;
        e.imm = (top << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      7'h33: e.fmt = 6;
      7'h3B: begin
        if (xl == 64) e.fmt = 6;
        else e.ill = 1;
      end
      default: e.ill = 1;
    endcase
    if (xl == 32) e.imm[63:32] = '0;
    e.tgt = tgt_of(e.fmt, pcv, e.imm, xl);
    return e;
  endfunction

  task automatic send(input logic [31:0] ins, input bit dir, input logic [63:0] c32,
                      input logic [63:0] c64, input logic [2:0] cf, input logic ci);
    exp_t        e32, e64;
    bit          a32, a64;
    logic [63:0] pcv;
    pcv = dir ? 64'd0 : {$urandom, $urandom};
    e32 = model(ins, 32, pcv);
    e64 = model(ins, 64, pcv);
    if (dir) begin
      e32.imm = c32; e32.fmt = cf; e32.ill = ci; e32.tgt = tgt_of(cf, pcv, c32, 32);
      e64.imm = c64; e64.fmt = cf; e64.ill = ci; e64.tgt = tgt_of(cf, pcv, c64, 64);
    end
    in_instr = ins;
`ifdef IMM_GEN_PCADD_EN
    pc = pcv;
`endif
    in_valid = 1'b1;
    a32 = 1'b0;
    a64 = 1'b0;
    for (int k = 0; k < 64 && !a32; k++) begin
      @(negedge clock);
      a32 = in_ready32;
      a64 = in_ready64;
    end
    @(posedge clock);
    #1;
    if (!a32) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout instr=%h never accepted", ins);
    end
    if (a32) q32.push_back(e32);
    if (a64) q64.push_back(e64);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 200 && (q32.size() != 0 || q64.size() != 0); k++) @(posedge clock);
    #1;
    chk(name, 64'(q32.size() + q64.size()), 64'd0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      chk("in_ready32_vs_count", 64'(in_ready32), 64'(q32.size() < 2));
      chk("out_valid32_vs_count", 64'(out_valid32), 64'(q32.size() > 0));
      chk("in_ready64_vs_count", 64'(in_ready64), 64'(q64.size() < 2));
      chk("out_valid64_vs_count", 64'(out_valid64), 64'(q64.size() > 0));
      if (out_valid32 && out_ready && q32.size() > 0) begin
        e = q32.pop_front();
        chk("imm32", 64'(out_imm32), e.imm);
        chk("fmt32", 64'(out_fmt32), 64'(e.fmt));
        chk("ill32", 64'(out_ill32), 64'(e.ill));
`ifdef IMM_GEN_PCADD_EN
        chk("tgt32", 64'(out_tgt32), e.tgt);
`endif
        pops++;
      end
      if (out_valid64 && out_ready && q64.size() > 0) begin
        e = q64.pop_front();
        chk("imm64", out_imm64, e.imm);
        chk("fmt64", 64'(out_fmt64), 64'(e.fmt));
        chk("ill64", 64'(out_ill64), 64'(e.ill));
`ifdef IMM_GEN_PCADD_EN
        chk("tgt64", out_tgt64, e.tgt);
`endif
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
    chk({tag, "_in_ready32"}, 64'(in_ready32), 64'd1);
    chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
    chk({tag, "_fmt32"}, 64'(out_fmt32), 64'd0);
    chk({tag, "_ill32"}, 64'(out_ill32), 64'd0);
    chk({tag, "_out_valid64"}, 64'(out_valid64), 64'd0);
    chk({tag, "_in_ready64"}, 64'(in_ready64), 64'd1);
    chk({tag, "_imm64"}, out_imm64, 64'd0);
`ifdef IMM_GEN_PCADD_EN
    chk({tag, "_tgt32"}, 64'(out_tgt32), 64'd0);
    chk({tag, "_tgt64"}, out_tgt64, 64'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] ins;
    int          p0, idx;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;
    ready_force = 1'b1;
    @(posedge clock);
    #1;

    send(32'hFFF00093, 1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    send(32'hFE000EE3, 1, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    send(32'h123452B7, 1, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    send(32'h0010006F, 1, 64'h0000_0800, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
    send(32'h43F0D093, 1, 64'h0000_001F, 64'h0000_0000_0000_003F, 3'd1, 1'b0);
    send(32'h0000007F, 1, 64'd0, 64'd0, 3'd0, 1'b1);
    send(32'h8000_0537, 1, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    wait_drain("directed_drain");

    // three back-to-back instructions against a stalled consumer
    @(negedge clock);
    ready_force = 1'b0;
    @(posedge clock);
    #1;
    grp_done = 1'b0;
    fork
      begin
        send(32'h00500113, 0, 0, 0, 0, 0);
        send(32'hFE112E23, 0, 0, 0, 0, 0);
        send(32'hFFDFF06F, 0, 0, 0, 0, 0);
        grp_done = 1'b1;
      end
    join_none
    repeat (3) @(negedge clock);
    #1;
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    chk("bp_out_valid", 64'(out_valid32), 64'd1);
    repeat (2) @(negedge clock);
    #1;
    chk("bp_still_stalled", 64'(in_ready32), 64'd0);
    ready_force = 1'b1;
    p0 = pops;
    repeat (3) @(negedge clock);
    #1;
    chk("bp_one_per_cycle", 64'(pops - p0), 64'd3);
    for (int k = 0; k < 50 && !grp_done; k++) @(posedge clock);
    chk("bp_group_done", 64'(grp_done), 64'd1);
    wait_drain("bp_drain");

    // asynchronous reset with both entries occupied
    @(negedge clock);
    ready_force = 1'b0;
    @(posedge clock);
    #1;
    send(32'h00A00093, 0, 0, 0, 0, 0);
    send(32'h00B00093, 0, 0, 0, 0, 0);
    #1;
    chk("pre_reset_full", 64'(in_ready32), 64'd0);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid");
    q32.delete();
    q64.delete();
    @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    ready_force = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("no_stale_after_reset", 64'(out_valid32 | out_valid64), 64'd0);

    // randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      idx = $urandom_range(0, 12);
      ins = $urandom;
      ins[6:0] = (idx == 12) ? 7'($urandom) : ops[idx];
      send(ins, 0, 0, 0, 0, 0);
    end
    rand_rdy = 1'b0;
    wait_drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
